h_logic_pipe: RTL and testbench

//  Parametrised, registered bitwise logic unit that generalises the 16-bit inverter
//  to a selectable 8-operation bitwise unit of any width.

---
 rtl/h_logic_pipe.sv | 126 ++++++++++++
 tb/tb_h_logic_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/h_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : h_logic_pipe
// Description : Registered WIDTH-bit bitwise logic unit (NOT/AND/OR/XOR/NAND/
//               NOR/XNOR/PASS) behind a valid/ready handshake. An output
//               register plus one skid entry give one result per cycle while
//               keeping in_ready a pure flop output.
// Revision    : 1.0 - initial release
// ============================================================================
module h_logic_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  // Operation encodings
  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Output register and skid entry
  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             out_zero_r;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_zero;

  // Combinational result of the pair currently on the inputs
  logic [WIDTH-1:0] result;
  logic             result_zero;

  // Handshake qualifiers
  logic accept;     // pair taken at this edge
  logic load_ok;    // output register is empty or being drained at this edge
  logic skid_move;  // skid entry moves into the output register at this edge

  // in_ready depends only on the skid flop, never on out_ready/in_valid
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & ~skid_valid;
  assign load_ok   = ~out_valid_r | out_ready;
  assign skid_move = skid_valid & out_ready;

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign out_zero  = out_zero_r;

  // Bitwise operation select; b is unused by NOT and PASS
  always_comb begin
    result = '0;
    case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = '0;
    endcase
    result_zero = ~|result;
  end

  // Occupancy control: skid only fills while the output register is stalled,
  // so skid_valid implies out_valid_r and a skid drain never coincides with
  // an accept (in_ready is low while the skid is full)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (load_ok) begin
        out_valid_r <= 1'b1;
      end else begin
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Data path: out/out_zero change only when a new result is loaded, so they
  // stay stable while stalled and hold their last value once drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r      <= '0;
      out_zero_r <= 1'b1;
      skid_data  <= '0;
      skid_zero  <= 1'b1;
    end else begin
      if (skid_move) begin
        out_r      <= skid_data;
        out_zero_r <= skid_zero;
      end else if (accept && load_ok) begin
        out_r      <= result;
        out_zero_r <= result_zero;
      end
      if (accept && !load_ok) begin
        skid_data <= result;
        skid_zero <= result_zero;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_h_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_h_logic_pipe
// Description : Self-checking bench for h_logic_pipe at WIDTH 1, 16 and 37.
//               All three instances share one handshake stream; a queue model
//               of the two-deep unit predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_h_logic_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [36:0] a_drv = '0;
  logic [36:0] b_drv = '0;

  logic        rdy1, rdy16, rdy37;
  logic        vld1, vld16, vld37;
  logic        z1, z16, z37;
  logic [0:0]  out1;
  logic [15:0] out16;
  logic [36:0] out37;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  h_logic_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a_drv[0:0]), .b(b_drv[0:0]), .op(op),
    .out_valid(vld1), .out_ready(out_ready), .out(out1), .out_zero(z1)
  );

  h_logic_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .op(op),
    .out_valid(vld16), .out_ready(out_ready), .out(out16), .out_zero(z16)
  );

  h_logic_pipe #(.WIDTH(37)) dut37 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy37),
    .a(a_drv), .b(b_drv), .op(op),
    .out_valid(vld37), .out_ready(out_ready), .out(out37), .out_zero(z37)
  );

  // Bitwise ops commute with bit slicing, so one 37-bit model serves all widths
  function automatic logic [36:0] f_op(input logic [2:0] o, input logic [36:0] x,
                                       input logic [36:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x & y);
      3'd5:    return ~(x | y);
      3'd6:    return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: a FIFO of capacity two; the head is on out, last shown value held
  logic [36:0] q[$];
  logic [36:0] last = '0;
  bit          m_acc, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last = '0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(f_op(op, a_drv, b_drv));
      if (q.size() > 0) last = q[0];
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready1",  64'(rdy1),  64'(q.size() < 2));
      check("in_ready16", 64'(rdy16), 64'(q.size() < 2));
      check("in_ready37", 64'(rdy37), 64'(q.size() < 2));
      check("out_valid1",  64'(vld1),  64'(q.size() > 0));
      check("out_valid16", 64'(vld16), 64'(q.size() > 0));
      check("out_valid37", 64'(vld37), 64'(q.size() > 0));
      check("out1",  64'(out1),  64'(last[0:0]));
      check("out16", 64'(out16), 64'(last[15:0]));
      check("out37", 64'(out37), 64'(last));
      check("zero1",  64'(z1),  64'(last[0:0] == 1'b0));
      check("zero16", 64'(z16), 64'(last[15:0] == 16'h0));
      check("zero37", 64'(z37), 64'(last == 37'h0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [36:0] x,
                       input logic [36:0] y);
    in_valid = v;
    op       = o;
    a_drv    = x;
    b_drv    = y;
  endtask

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [15:0] t2_exp [1:7];
  logic [63:0] rnd;

  initial begin
    t2_exp[1] = 16'hF000; t2_exp[2] = 16'hFFF0; t2_exp[3] = 16'h0FF0;
    t2_exp[4] = 16'h0FFF; t2_exp[5] = 16'h000F; t2_exp[6] = 16'hF00F;
    t2_exp[7] = 16'hF0F0;

    // Reset state
    #12;
    check("rst_out",       64'(out16), 64'h0);
    check("rst_zero",      64'(z16),   64'h1);
    check("rst_out_valid", 64'(vld16), 64'h0);
    check("rst_in_ready",  64'(rdy16), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // T1: NOT
    drive(1'b1, 3'd0, 37'h00FF, 37'h0);
    cyc();
    drive(1'b0, 3'd0, 37'h0, 37'h0);
    check("t1_out",   64'(out16), 64'hFF00);
    check("t1_valid", 64'(vld16), 64'h1);
    check("t1_zero",  64'(z16),   64'h0);

    // T2: ops 1..7 back to back
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 3'(i), 37'hF0F0, 37'hFF00);
      cyc();
      check($sformatf("t2_op%0d", i), 64'(out16), 64'(t2_exp[i]));
      check($sformatf("t2_valid%0d", i), 64'(vld16), 64'h1);
    end

    // T3: XOR of equal operands gives zero
    drive(1'b1, 3'd3, 37'h1234, 37'h1234);
    cyc();
    check("t3_out",  64'(out16), 64'h0);
    check("t3_zero", 64'(z16),   64'h1);
    drive(1'b0, 3'd0, 37'h0, 37'h0);
    cyc();

    // T4: stall with three pairs offered
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 37'h1, 37'h0);
    cyc();
    check("t4_a_out",   64'(out16), 64'h1);
    check("t4_a_ready", 64'(rdy16), 64'h1);
    drive(1'b1, 3'd7, 37'h2, 37'h0);
    cyc();
    check("t4_b_out",   64'(out16), 64'h1);
    check("t4_b_ready", 64'(rdy16), 64'h0);
    drive(1'b1, 3'd7, 37'h3, 37'h0);
    cyc();
    check("t4_c_out",   64'(out16), 64'h1);
    check("t4_c_ready", 64'(rdy16), 64'h0);
    out_ready = 1'b1;
    cyc();
    check("t4_d_out",   64'(out16), 64'h2);
    check("t4_d_ready", 64'(rdy16), 64'h1);
    cyc();
    check("t4_e_out",   64'(out16), 64'h3);
    check("t4_e_valid", 64'(vld16), 64'h1);
    drive(1'b0, 3'd0, 37'h0, 37'h0);
    cyc();
    check("t4_f_valid", 64'(vld16), 64'h0);
    check("t4_f_out",   64'(out16), 64'h3);

    // T5: asynchronous reset with output and skid full
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 37'hAAAA, 37'h0);
    cyc();
    drive(1'b1, 3'd7, 37'h5555, 37'h0);
    cyc();
    drive(1'b0, 3'd0, 37'h0, 37'h0);
    check("t5_pre_ready", 64'(rdy16), 64'h0);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", 64'(vld16), 64'h0);
    check("t5_ready", 64'(rdy16), 64'h1);
    check("t5_out",   64'(out16), 64'h0);
    check("t5_zero",  64'(z16),   64'h1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 37'h0BEE, 37'h0);
    cyc();
    check("t5_first_out",   64'(out16), 64'h0BEE);
    check("t5_first_valid", 64'(vld16), 64'h1);
    drive(1'b0, 3'd0, 37'h0, 37'h0);
    cyc();

    // T6: random traffic on all widths, checked by the model every cycle
    repeat (1000) begin
      rnd = {$urandom(), $urandom()};
      a_drv = rnd[36:0];
      rnd = {$urandom(), $urandom()};
      b_drv = rnd[36:0];
      op        = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
